instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Clocking SHALL be one clock, clk_i; reset rst_i SHALL be synchronous and active-high.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 stall_d_i  in  1  decode stalled; D register holds.
REQ-006 pc_src_d_i  in  1  taken branch resolved in decode.
REQ-007 pc_branch_d_i  in  32  branch target.
REQ-008 jump_d_i  in  1  jump resolved in decode.
REQ-009 pc_jump_d_i  in  32  jump target.
REQ-010 imem_req_o  out  1  instruction memory request.
REQ-011 imem_addr_o  out  32  request address (= pc_q).
REQ-012 imem_gnt_i  in  1  request accepted this cycle.
REQ-013 imem_rvalid_i  in  1  response valid; arrives >=1 cycle after grant.
REQ-014 imem_rdata_i  in  32  response instruction word.
REQ-015 instr_d_o  out  32  D-register instruction to decode.
REQ-016 pc_plus_4_d_o  out  32  D-register fetch address + 4.
REQ-017 pc_f_o  out  32  current pc_q (debug/hazard).

Function
REQ-018 Redirect = (stall_d_i==0) & (jump_d_i | pc_src_d_i); target = jump_d_i ? pc_jump_d_i : pc_branch_d_i (jump priority); redirect ignored while stall_d_i=1.
REQ-019 At most one memory request outstanding; states REQ, WAIT, DROP, FULL; 2-bit state.
REQ-020 REQ: imem_req_o=1, imem_addr_o=pc_q; address may change only while ungranted.
REQ-021 REQ, gnt & ~redirect: infl_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32), ->WAIT.
REQ-022 REQ, gnt & redirect: pc_q<=target, ->DROP; REQ, ~gnt & redirect: pc_q<=target, stay REQ.
REQ-023 WAIT: imem_req_o=0; rvalid & redirect -> discard data, pc_q<=target, ->REQ; ~rvalid & redirect -> pc_q<=target, ->DROP.
REQ-024 WAIT, rvalid & ~redirect & ~stall_d_i: D loads {imem_rdata_i, infl_pc+4}, ->REQ.
REQ-025 WAIT, rvalid & stall_d_i: buf<=imem_rdata_i, buf_pc4<=infl_pc+4, ->FULL.
REQ-026 DROP: imem_req_o=0; rvalid discarded, ->REQ; further redirects update pc_q only.
REQ-027 FULL: imem_req_o=0; on ~stall_d_i & ~redirect D loads buffer, ->REQ; on redirect buffer discarded, pc_q<=target, ->REQ.
REQ-028 D register: stall_d_i=1 holds; else redirect loads bubble (instr 0, pc4 0); else delivered instruction per REQ-024/027; else bubble.
REQ-029 Redirect kills any same-cycle delivery; no delay slot.
REQ-030 rvalid in REQ state SHALL be ignored (protocol error, no state change).
REQ-031 Best-case throughput one instruction per 2 cycles (gnt same cycle as req, rvalid next cycle).

Reset
REQ-032 rst_i=1: pc_q<=RESET_PC, state<=REQ, instr_d_o=0, pc_plus_4_d_o=0, buf=0, infl_pc=0; imem_req_o=1 in first cycle after reset deasserts.
REQ-033 Reset mid-request abandons outstanding transaction; a later rvalid is consumed as in REQ-030 and ignored.
REQ-034 Reset overrides all other inputs in the same cycle.

Verification
REQ-035 Reset, gnt always 1, rvalid 1 cycle after gnt, data 0x20080005, 0x20090007 -> D sees 0x20080005/pc4 0x4, bubble, 0x20090007/pc4 0x8; addresses 0x0, 0x4.
REQ-036 rvalid with stall_d_i=1 for 3 cycles, data 0x8C0A0000 -> FULL, no req, D holds old value, then D=0x8C0A0000 on first unstalled edge, req resumes.
REQ-037 Redirect pc_src_d_i=1, target 0x40, while WAIT -> DROP; pending rvalid discarded; next request address 0x40; D bubble.
REQ-038 jump_d_i and pc_src_d_i both 1, targets 0x100/0x200 -> next request address 0x100.
REQ-039 pc_src_d_i=1 with stall_d_i=1 -> no redirect, pc_q unchanged; redirect taken when stall drops.
REQ-040 pc_q=0xFFFFFFFC granted -> pc_q wraps to 0x0, pc_plus_4_d_o=0x0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface instr_fetch_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: single-outstanding imem requester feeding the decode (D) register,
// with decode-resolved branch/jump redirect and a one-entry skid buffer for stalls.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           stall_d_i,
  input  logic           pc_src_d_i,
  input  logic [31:0]    pc_branch_d_i,
  input  logic           jump_d_i,
  input  logic [31:0]    pc_jump_d_i,
  instr_fetch_if.master  imem,
  output logic [31:0]    instr_d_o,
  output logic [31:0]    pc_plus_4_d_o,
  output logic [31:0]    pc_f_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_FULL = 2'd3
  } state_e;

  state_e          state_q;
  logic            req_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] infl_pc_q;
  logic [XLEN-1:0] buf_q;
  logic [XLEN-1:0] buf_pc4_q;
  logic [XLEN-1:0] instr_d_q;
  logic [XLEN-1:0] pc4_d_q;

  logic            redirect;
  logic [XLEN-1:0] target;

  // Redirect only when decode is not stalled; jump wins over branch.
  assign redirect = ~stall_d_i & (jump_d_i | pc_src_d_i);
  assign target   = jump_d_i ? pc_jump_d_i : pc_branch_d_i;

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = pc_q;
  assign instr_d_o        = instr_d_q;
  assign pc_plus_4_d_o    = pc4_d_q;
  assign pc_f_o           = pc_q;

  // Fetch FSM, PC, skid buffer and D register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_REQ;
      req_q     <= 1'b1;
      pc_q      <= RESET_PC;
      infl_pc_q <= '0;
      buf_q     <= '0;
      buf_pc4_q <= '0;
      instr_d_q <= '0;
      pc4_d_q   <= '0;
    end else begin
      // Unstalled D defaults to a bubble; delivery branches below override it.
      if (!stall_d_i) begin
        instr_d_q <= '0;
        pc4_d_q   <= '0;
      end

      unique case (state_q)
        ST_REQ: begin
          // rvalid here is a protocol error and is ignored.
          if (redirect) begin
            pc_q <= target;
            if (imem.imem_gnt_i) begin
              state_q <= ST_DROP;
              req_q   <= 1'b0;
            end
          end else if (imem.imem_gnt_i) begin
            infl_pc_q <= pc_q;
            pc_q      <= pc_q + XLEN'(4);
            state_q   <= ST_WAIT;
            req_q     <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (redirect) begin
            pc_q <= target;
            if (imem.imem_rvalid_i) begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end else begin
              state_q <= ST_DROP;
            end
          end else if (imem.imem_rvalid_i) begin
            if (stall_d_i) begin
              buf_q     <= imem.imem_rdata_i;
              buf_pc4_q <= infl_pc_q + XLEN'(4);
              state_q   <= ST_FULL;
            end else begin
              instr_d_q <= imem.imem_rdata_i;
              pc4_d_q   <= infl_pc_q + XLEN'(4);
              state_q   <= ST_REQ;
              req_q     <= 1'b1;
            end
          end
        end

        ST_DROP: begin
          if (redirect) begin
            pc_q <= target;
          end
          if (imem.imem_rvalid_i) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
          end
        end

        ST_FULL: begin
          if (redirect) begin
            pc_q    <= target;
            state_q <= ST_REQ;
            req_q   <= 1'b1;
          end else if (!stall_d_i) begin
            instr_d_q <= buf_q;
            pc4_d_q   <= buf_pc4_q;
            state_q   <= ST_REQ;
            req_q     <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
